// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
// The entry layout is fixed here; the top-level width parameters default to
// these values and must be kept equal to them.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int PTR_W    = $clog2(SB_DEPTH);

  // One buffered store: word address (byte offset dropped) plus data.
  typedef struct packed {
    logic [SB_AW-3:0] waddr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Word address of a byte address; the low two bits select a byte and are ignored.
  function automatic logic [SB_AW-3:0] word_addr(input logic [SB_AW-1:0] addr);
    return addr[SB_AW-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// Load-forwarding search: finds the youngest valid entry whose word address
// matches the load, scanning the circular array in age order from wr_ptr.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t [DEPTH-1:0]         entries,
  input  logic      [DEPTH-1:0]         valid,
  input  logic      [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic      [SB_AW-3:0]         waddr,
  output logic                          hit,
  output logic      [SB_DW-1:0]         data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so that a later (younger) match overrides an earlier one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (valid[idx] && entries[idx].waddr == waddr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: accepts core stores in one cycle, drains them in
// order over a valid/ready memory bus, forwards pending data to loads and
// coalesces back-to-back stores to the same word into the youngest entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     mem_valid,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] entries;
  logic      [PW-1:0]    wr_ptr;
  logic      [PW-1:0]    rd_ptr;
  logic      [CW-1:0]    cnt;

  logic                  not_empty;
  logic                  not_full;
  logic      [PW-1:0]    young_idx;
  logic                  st_match;
  logic                  deq;
  logic                  coal;
  logic                  enq;
  logic      [DEPTH-1:0] valid;
  sb_entry_t             head;

  // Handshake and occupancy decode, all from registered state plus core inputs.
  always_comb begin
    not_empty = (cnt != '0);
    not_full  = (cnt < CW'(DEPTH));
    young_idx = wr_ptr - PW'(1);
    head      = entries[rd_ptr];
    st_match  = st_valid && not_empty && (word_addr(st_addr) == entries[young_idx].waddr);
    deq       = not_empty && mem_ready;
    // When the only entry leaves this cycle, a matching store must become a fresh entry.
    coal      = st_match && !((cnt == CW'(1)) && deq);
    enq       = st_valid && !coal && not_full;
    // The dequeue exclusion in coal only matters when count==1, where not_full
    // already grants acceptance; dropping it keeps mem_ready off the st_ready path.
    st_ready  = st_match || not_full;
  end

  // Valid mask: entry i is live if it lies within count slots of the head.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - rd_ptr} < cnt);
    end
  end

  assign mem_valid = not_empty;
  assign mem_addr  = {head.waddr, 2'b00};
  assign mem_data  = head.data;
  assign count     = cnt;
  assign empty     = !not_empty;

  store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
    .entries (entries),
    .valid   (valid),
    .wr_ptr  (wr_ptr),
    .waddr   (word_addr(ld_addr)),
    .hit     (ld_hit),
    .data    (ld_data)
  );

  // Entry storage: new entries at wr_ptr, coalesced data into the youngest entry.
  // NOTE: the entry array has no reset; its contents only matter under the valid mask, which reset clears.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[wr_ptr] <= '{waddr: word_addr(st_addr), data: st_data};
    end else if (coal) begin
      entries[young_idx].data <= st_data;
    end
  end

  // Pointers and occupancy; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(enq) - CW'(deq);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: acceptance, drain order, coalescing,
// forwarding, pointer wrap and asynchronous reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [2:0]  count;
  logic        empty;

  int total = 0;
  int bad   = 0;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .count     (count),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present one store, take the edge, then withdraw the request.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
    settle();
  endtask

  logic [31:0] exp_addr [12];
  logic [31:0] exp_data [12];
  logic [31:0] drain_a  [4];
  logic [31:0] drain_d  [4];
  int          n_st;
  int          n_rx;
  int          cyc;
  bit          stable;

  initial begin
    reset     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    ld_addr   = 32'h54;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    settle();

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_ld_hit", ld_hit, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_st_ready", st_ready, 1);

    // Single store, held off by memory, then drained
    @(posedge clk); #1;
    st_valid = 1'b1; st_addr = 32'h54; st_data = 32'd7;
    settle();
    check("t1_st_ready", st_ready, 1);
    tick();
    st_valid = 1'b0;
    settle();
    check("t1_count", count, 1);
    check("t1_mem_valid", mem_valid, 1);
    check("t1_mem_addr", mem_addr, 32'h54);
    check("t1_mem_data", mem_data, 7);
    check("t1_fwd_hit", ld_hit, 1);
    check("t1_fwd_data", ld_data, 7);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_valid !== 1'b1 || mem_addr !== 32'h54 || mem_data !== 32'd7 || count !== 3'd1)
        stable = 1'b0;
    end
    check("t1_stall_stable", stable, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    settle();
    check("t1_drained_count", count, 0);
    check("t1_drained_empty", empty, 1);

    // Fill to DEPTH, reject new word, accept coalescing store, drain in order
    store(32'h00, 32'hA0);
    store(32'h04, 32'hA1);
    store(32'h08, 32'hA2);
    store(32'h0C, 32'hA3);
    check("t2_full_count", count, 4);
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hCC;
    settle();
    check("t2_full_reject", st_ready, 0);
    mem_ready = 1'b1;
    settle();
    check("t2_full_reject_deq", st_ready, 0);
    mem_ready = 1'b0;
    st_addr = 32'h0C; st_data = 32'hBB;
    settle();
    check("t2_coal_accept", st_ready, 1);
    tick();
    st_valid = 1'b0;
    settle();
    check("t2_coal_count", count, 4);
    drain_a = '{32'h00, 32'h04, 32'h08, 32'h0C};
    drain_d = '{32'hA0, 32'hA1, 32'hA2, 32'hBB};
    mem_ready = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain_addr%0d", i), mem_addr, drain_a[i]);
      check($sformatf("t2_drain_data%0d", i), mem_data, drain_d[i]);
      tick();
    end
    mem_ready = 1'b0;
    settle();
    check("t2_end_count", count, 0);

    // Forwarding picks the youngest of several matches
    store(32'h40, 32'd1);
    store(32'h44, 32'd2);
    store(32'h40, 32'd3);
    check("t3_count", count, 3);
    ld_addr = 32'h42;
    settle();
    check("t3_hit_40", ld_hit, 1);
    check("t3_data_40", ld_data, 3);
    ld_addr = 32'h44;
    settle();
    check("t3_data_44", ld_data, 2);
    ld_addr = 32'h80;
    settle();
    check("t3_miss_hit", ld_hit, 0);
    check("t3_miss_data", ld_data, 0);
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    settle();
    check("t3_end_count", count, 0);

    // Same word as a departing sole entry: new entry, not a coalesce
    store(32'h20, 32'd5);
    mem_ready = 1'b1;
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'd6;
    ld_addr = 32'h20;
    settle();
    check("t4_st_ready", st_ready, 1);
    check("t4_fwd_deq_entry", ld_data, 5);
    tick();
    st_valid = 1'b0;
    mem_ready = 1'b0;
    settle();
    check("t4_count", count, 1);
    check("t4_mem_addr", mem_addr, 32'h20);
    check("t4_mem_data", mem_data, 6);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    settle();
    check("t4_end_count", count, 0);

    // Continuous streaming with pointer wrap
    for (int i = 0; i < 12; i++) begin
      exp_addr[i] = 32'h100 + 32'(4 * i);
      exp_data[i] = 32'h1000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) store(exp_addr[i], exp_data[i]);
    check("t5_fill_count", count, 4);
    n_st = 4;
    n_rx = 0;
    cyc  = 0;
    mem_ready = 1'b1;
    while (n_rx < 12 && cyc < 100) begin
      st_valid = (n_st < 12);
      if (n_st < 12) begin
        st_addr = exp_addr[n_st];
        st_data = exp_data[n_st];
      end
      settle();
      if (mem_valid) begin
        check($sformatf("t5_addr%0d", n_rx), mem_addr, exp_addr[n_rx]);
        check($sformatf("t5_data%0d", n_rx), mem_data, exp_data[n_rx]);
        n_rx++;
      end
      if (st_valid && st_ready) n_st++;
      tick();
      cyc++;
    end
    st_valid = 1'b0;
    mem_ready = 1'b0;
    settle();
    check("t5_rx_total", n_rx, 12);
    check("t5_end_count", count, 0);

    // Asynchronous reset in the middle of a drain
    store(32'h300, 32'd11);
    store(32'h304, 32'd12);
    store(32'h308, 32'd13);
    check("t6_count", count, 3);
    ld_addr = 32'h304;
    mem_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_mem_valid", mem_valid, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_ld_hit", ld_hit, 0);
    @(negedge clk);
    reset = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_valid !== 1'b0) stable = 1'b0;
    end
    check("t6_no_stale", stable, 1);
    mem_ready = 1'b0;
    store(32'h200, 32'd9);
    check("t6_post_addr", mem_addr, 32'h200);
    check("t6_post_data", mem_data, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
Posted-write buffer between the core's data-memory store port (memwrite/dataadr/writedata) and a slower data-memory bus with a valid/ready handshake.
- Stores retire from the core in one cycle unless the buffer is full; entries drain in order to memory.
- Load addresses are checked against pending stores and forwarded, so the core reads its own writes before they reach memory.
- Back-to-back stores to the same word are coalesced into the youngest entry.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
AW, 32, byte-address width
DW, 32, data word width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
st_valid  input  1  core store request (driven by memwrite)
st_addr  input  AW  store byte address; bits [1:0] ignored
st_data  input  DW  store data
st_ready  output  1  store accepted this cycle; 0 stalls the core
ld_addr  input  AW  load byte address for the forwarding check; bits [1:0] ignored
ld_hit  output  1  a pending store matches ld_addr's word
ld_data  output  DW  data of the youngest matching entry; 0 when ld_hit=0
mem_valid  output  1  head entry presented to memory
mem_addr  output  AW  head word address, bits [1:0]=2'b00
mem_data  output  DW  head data
mem_ready  input  1  memory accepts the head this cycle
count  output  $clog2(DEPTH)+1  number of valid entries
empty  output  1  count==0

Behaviour:
- Storage: circular array of {word address AW-2 bits, data DW}. Write pointer, read pointer and count are registers. Pointers wrap modulo DEPTH.
- Reset (reset=0, asynchronous): pointers=0, count=0, empty=1, mem_valid=0, ld_hit=0, ld_data=0. Entry contents are don't-care. Reset asserted mid-drain discards all entries immediately, with no handshake completion. mem_valid drops asynchronously.
- Drain: mem_valid = !empty. mem_addr and mem_data are driven from the head registers.
  - Dequeue on mem_valid & mem_ready: rd_ptr+1, count-1.
  - mem_addr and mem_data stay stable while mem_valid=1 and mem_ready=0.
  - There is no combinational path from mem_ready to any output except through registers.
- Coalesce condition (coal): st_valid & count!=0 & st_addr word == youngest entry's word & !(count==1 & dequeue this cycle).
  - On coal, overwrite the youngest entry's data. No enqueue, count unaffected by the store.
- Enqueue: st_valid & !coal & count<DEPTH.
  - Write the entry at wr_ptr, then wr_ptr+1.
- st_ready = coal | (count<DEPTH).
  - A full buffer still accepts a coalescing store.
  - A full buffer does not accept a new entry in the same cycle a dequeue frees one (no mem_ready -> st_ready path).
- Count update: count_next = count + enqueue - dequeue. Simultaneous enqueue and dequeue leaves count unchanged.
- Empty buffer: an enqueue is visible on mem_valid the following cycle (1-cycle latency store->bus). There is no bypass.
- Forwarding (combinational):
  - Compare ld_addr[AW-1:2] against all valid entries.
  - ld_hit = any match.
  - ld_data = data of the youngest match (closest to wr_ptr).
  - Same-cycle incoming stores are not forwarded.
  - An entry being dequeued this cycle still forwards this cycle.
- Stall semantics: the core holds st_valid/st_addr/st_data while st_ready=0. Behaviour with changing inputs under stall is undefined.

Decomposition:
- Package store_buffer_pkg:
  - sb_entry_t packed struct {logic [AW-3:0] waddr; logic [DW-1:0] data;}
  - function word_addr(byte addr) returning addr[AW-1:2]
  - localparam PTR_W = $clog2(DEPTH)
- One sub-module: store_buffer_fwd.
  - Purely combinational youngest-match priority search over the entry array, valid mask and wr_ptr.
  - Outputs hit and data.
  - Keeps the priority rotation logic testable on its own.

Test Plan:
- Reset, then st_valid with addr 0x54 and data 7 while mem_ready=0:
  - st_ready=1, count=1 the next cycle, mem_valid=1, mem_addr=0x54, mem_data=7.
  - Hold mem_ready=0 for 5 cycles: outputs stable.
  - mem_ready=1: count=0 the next cycle.
- With mem_ready=0, issue 4 stores to 0x00, 0x04, 0x08, 0x0C:
  - count=4, st_ready=0 for a 5th store to 0x10.
  - A 5th store to 0x0C is accepted (coalesced) and its data replaces entry 3.
  - Drain order is 0x00, 0x04, 0x08, 0x0C.
- Stores 0x40<-1, 0x44<-2, 0x40<-3, then ld_addr=0x42:
  - ld_hit=1, ld_data=3 (youngest of two matches).
  - ld_addr=0x80: ld_hit=0, ld_data=0.
- count=1 with head 0x20, mem_ready=1, st_valid to 0x20 in the same cycle:
  - No coalesce; a new entry is enqueued, count stays 1.
  - The next mem transaction carries the new data.
- Fill to 4, drain with mem_ready=1 continuously while storing every cycle:
  - Pointers wrap past DEPTH-1 correctly.
  - After 12 stores, memory receives 12 writes in order with no loss or duplication.
- Assert reset=0 mid-drain with count=3:
  - mem_valid=0, count=0, empty=1 immediately, before the next clock edge.
  - After reset release, no stale entries appear on mem_valid.
